// File: rtl/fwd_hazard_unit_if.sv
// Operand, pipeline-stage and stall signals shared between the datapath and the
// forwarding/hazard unit.
interface fwd_hazard_unit_if #(
    parameter int unsigned NOPER   = 2,
    parameter int unsigned NFWD    = 2,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CNT_W   = 16
) ();
    localparam int unsigned SRC_W = $clog2(NFWD + 2);

    logic [NOPER*RADDR_W-1:0] ex_rs;
    logic [NOPER*DATA_W-1:0]  ex_rf_data;
    logic [NFWD-1:0]          st_regwr;
    logic [NFWD*RADDR_W-1:0]  st_dest;
    logic [NFWD*DATA_W-1:0]   st_data;
    logic [NFWD-1:0]          st_load;
    logic [NFWD-1:0]          st_dvalid;
    logic                     ex_memread;
    logic [RADDR_W-1:0]       ex_wrdest;
    logic [NOPER*RADDR_W-1:0] id_rs;
    logic                     id_valid;
    logic                     pipe_en;
    logic [NOPER*DATA_W-1:0]  fwd_data;
    logic [NOPER*SRC_W-1:0]   fwd_src;
    logic                     stall_id;
    logic                     stall_ex;
    logic [CNT_W-1:0]         stall_cnt;

    modport master (
        output ex_rs, ex_rf_data, st_regwr, st_dest, st_data, st_load, st_dvalid,
               ex_memread, ex_wrdest, id_rs, id_valid, pipe_en,
        input  fwd_data, fwd_src, stall_id, stall_ex, stall_cnt
    );

    modport slave (
        input  ex_rs, ex_rf_data, st_regwr, st_dest, st_data, st_load, st_dvalid,
               ex_memread, ex_wrdest, id_rs, id_valid, pipe_en,
        output fwd_data, fwd_src, stall_id, stall_ex, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Resolves EX operands against downstream stages (youngest first), holds forwarded
// values across EX freezes, and raises pending-load and load-use stalls.
module fwd_hazard_unit #(
    parameter int unsigned NOPER   = 2,
    parameter int unsigned NFWD    = 2,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned CNT_W   = 16
) (
    input logic              CLK,
    input logic              RST,
    fwd_hazard_unit_if.slave bus
);
    localparam int unsigned      SRC_W    = $clog2(NFWD + 2);
    localparam logic [SRC_W-1:0] SRC_HOLD = SRC_W'(NFWD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {StRun, StLu, StMwait} state_e;

    state_e            state_q;
    logic [DATA_W-1:0] hold_q [NOPER];
    logic [NOPER-1:0]  hold_v_q;
    logic [CNT_W-1:0]  stall_cnt_q;

    logic [NOPER-1:0]  hit, pend, pending;
    logic [DATA_W-1:0] hit_data [NOPER];
    logic [SRC_W-1:0]  hit_src [NOPER];
    logic [NOPER*DATA_W-1:0] fwd_data;
    logic [NOPER*SRC_W-1:0]  fwd_src;
    logic lu, stall_ex, stall_id;

    always_comb begin
        hit = '0;
        pend = '0;
        for (int i = 0; i < NOPER; i++) begin
            hit_data[i] = '0;
            hit_src[i]  = '0;
            // Walk oldest to youngest so the youngest match overwrites the rest.
            for (int k = NFWD - 1; k >= 0; k--) begin
                if (bus.st_regwr[k] && bus.st_dest[k*RADDR_W +: RADDR_W] != '0 &&
                    bus.st_dest[k*RADDR_W +: RADDR_W] == bus.ex_rs[i*RADDR_W +: RADDR_W]) begin
                    hit[i]      = 1'b1;
                    pend[i]     = bus.st_load[k] && !bus.st_dvalid[k];
                    hit_data[i] = bus.st_data[k*DATA_W +: DATA_W];
                    hit_src[i]  = SRC_W'(k + 1);
                end
            end
        end
    end

    always_comb begin
        fwd_data = '0;
        fwd_src  = '0;
        pending  = '0;
        for (int i = 0; i < NOPER; i++) begin
            pending[i] = !RST && !hold_v_q[i] && hit[i] && pend[i];
            if (RST) begin
                fwd_data[i*DATA_W +: DATA_W] = bus.ex_rf_data[i*DATA_W +: DATA_W];
            end else if (hold_v_q[i]) begin
                fwd_data[i*DATA_W +: DATA_W] = hold_q[i];
                fwd_src[i*SRC_W +: SRC_W]    = SRC_HOLD;
            end else if (hit[i] && !pend[i]) begin
                fwd_data[i*DATA_W +: DATA_W] = hit_data[i];
                fwd_src[i*SRC_W +: SRC_W]    = hit_src[i];
            end else begin
                fwd_data[i*DATA_W +: DATA_W] = bus.ex_rf_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        lu = 1'b0;
        for (int i = 0; i < NOPER; i++) begin
            if (bus.id_rs[i*RADDR_W +: RADDR_W] == bus.ex_wrdest) lu = 1'b1;
        end
        lu       = lu && bus.id_valid && bus.ex_memread && bus.ex_wrdest != '0;
        stall_ex = |pending;
        stall_id = !RST && (stall_ex || (lu && state_q == StRun));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= StRun;
            hold_v_q    <= '0;
            stall_cnt_q <= '0;
            for (int i = 0; i < NOPER; i++) hold_q[i] <= '0;
        end else begin
            for (int i = 0; i < NOPER; i++) begin
                if (bus.pipe_en) begin
                    hold_v_q[i] <= 1'b0;
                end else if (!hold_v_q[i] && hit[i] && !pend[i]) begin
                    hold_q[i]   <= hit_data[i];
                    hold_v_q[i] <= 1'b1;
                end
            end
            case (state_q)
                StRun: begin
                    if (stall_ex)                  state_q <= StMwait;
                    else if (lu && bus.pipe_en)    state_q <= StLu;
                end
                StLu:    state_q <= StRun;
                StMwait: if (!stall_ex) state_q <= StRun;
                default: state_q <= StRun;
            endcase
            if ((stall_id || stall_ex) && stall_cnt_q != CNT_MAX) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.fwd_data  = fwd_data;
    assign bus.fwd_src   = fwd_src;
    assign bus.stall_ex  = stall_ex;
    assign bus.stall_id  = stall_id;
    assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a behavioural model.
module tb_fwd_hazard_unit;
    localparam int unsigned NOPER   = 2;
    localparam int unsigned NFWD    = 2;
    localparam int unsigned RADDR_W = 5;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned SRC_W   = $clog2(NFWD + 2);
    localparam int CNT_MAX    = (1 << CNT_W) - 1;
    localparam int MODE_RUN   = 0;
    localparam int MODE_LU    = 1;
    localparam int MODE_MWAIT = 2;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    // Stimulus, unpacked per operand / stage
    logic [RADDR_W-1:0] rs [NOPER];
    logic [DATA_W-1:0]  rf [NOPER];
    logic [NFWD-1:0]    regwr, load, dvalid;
    logic [RADDR_W-1:0] dest [NFWD];
    logic [DATA_W-1:0]  sdata [NFWD];
    logic               memread, id_valid, pipe_en;
    logic [RADDR_W-1:0] wrdest;
    logic [RADDR_W-1:0] id_rs [NOPER];

    fwd_hazard_unit_if #(.NOPER(NOPER), .NFWD(NFWD), .RADDR_W(RADDR_W), .DATA_W(DATA_W),
                         .CNT_W(CNT_W)) bus ();

    fwd_hazard_unit #(.NOPER(NOPER), .NFWD(NFWD), .RADDR_W(RADDR_W), .DATA_W(DATA_W),
                      .CNT_W(CNT_W)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    always_comb begin
        bus.ex_rs = '0;
        bus.ex_rf_data = '0;
        bus.id_rs = '0;
        bus.st_dest = '0;
        bus.st_data = '0;
        for (int i = 0; i < NOPER; i++) begin
            bus.ex_rs[i*RADDR_W +: RADDR_W]    = rs[i];
            bus.ex_rf_data[i*DATA_W +: DATA_W] = rf[i];
            bus.id_rs[i*RADDR_W +: RADDR_W]    = id_rs[i];
        end
        for (int k = 0; k < NFWD; k++) begin
            bus.st_dest[k*RADDR_W +: RADDR_W] = dest[k];
            bus.st_data[k*DATA_W +: DATA_W]   = sdata[k];
        end
    end
    assign bus.st_regwr   = regwr;
    assign bus.st_load    = load;
    assign bus.st_dvalid  = dvalid;
    assign bus.ex_memread = memread;
    assign bus.ex_wrdest  = wrdest;
    assign bus.id_valid   = id_valid;
    assign bus.pipe_en    = pipe_en;

    // Behavioural model state
    logic [DATA_W-1:0] m_hold [NOPER];
    logic [NOPER-1:0]  m_hold_v;
    int                m_mode;
    int                m_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [NOPER-1:0][DATA_W-1:0] data;
        logic [NOPER-1:0][SRC_W-1:0]  src;
        logic [NOPER-1:0]             cap;
        logic [NOPER-1:0][DATA_W-1:0] cap_data;
        logic                         sex;
        logic                         sid;
    } exp_t;

    function automatic exp_t eval_model();
        exp_t e;
        logic lu;
        e = '0;
        for (int i = 0; i < NOPER; i++) begin
            logic hit, pnd;
            logic [DATA_W-1:0] sd;
            int src;
            hit = 1'b0; pnd = 1'b0; sd = '0; src = 0;
            for (int k = 0; k < NFWD; k++) begin
                if (!hit && regwr[k] && dest[k] != 0 && dest[k] == rs[i]) begin
                    hit = 1'b1;
                    pnd = load[k] && !dvalid[k];
                    sd  = sdata[k];
                    src = k + 1;
                end
            end
            if (RST) begin
                e.data[i] = rf[i];
            end else if (m_hold_v[i]) begin
                e.data[i] = m_hold[i];
                e.src[i]  = SRC_W'(NFWD + 1);
            end else if (hit && !pnd) begin
                e.data[i] = sd;
                e.src[i]  = SRC_W'(src);
            end else begin
                e.data[i] = rf[i];
            end
            if (!RST && !m_hold_v[i] && hit && pnd) e.sex = 1'b1;
            e.cap[i]      = !m_hold_v[i] && hit && !pnd;
            e.cap_data[i] = sd;
        end
        lu = 1'b0;
        for (int i = 0; i < NOPER; i++) if (id_rs[i] == wrdest) lu = 1'b1;
        lu = lu && id_valid && memread && wrdest != 0;
        e.sid = !RST && (e.sex || (lu && m_mode == MODE_RUN));
        return e;
    endfunction

    task automatic model_reset();
        m_hold_v = '0;
        for (int i = 0; i < NOPER; i++) m_hold[i] = '0;
        m_mode = MODE_RUN;
        m_cnt  = 0;
    endtask

    task automatic model_edge();
        exp_t e;
        logic lu_go;
        e = eval_model();
        if (RST) begin
            model_reset();
        end else begin
            lu_go = e.sid && !e.sex && pipe_en;
            for (int i = 0; i < NOPER; i++) begin
                if (pipe_en) m_hold_v[i] = 1'b0;
                else if (e.cap[i]) begin
                    m_hold[i]   = e.cap_data[i];
                    m_hold_v[i] = 1'b1;
                end
            end
            if (m_mode == MODE_RUN)        m_mode = e.sex ? MODE_MWAIT : (lu_go ? MODE_LU : MODE_RUN);
            else if (m_mode == MODE_LU)    m_mode = MODE_RUN;
            else                           m_mode = e.sex ? MODE_MWAIT : MODE_RUN;
            if ((e.sid || e.sex) && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] dut_data(input int i);
        return bus.fwd_data[i*DATA_W +: DATA_W];
    endfunction

    function automatic logic [SRC_W-1:0] dut_src(input int i);
        return bus.fwd_src[i*SRC_W +: SRC_W];
    endfunction

    task automatic check_all();
        exp_t e;
        e = eval_model();
        for (int i = 0; i < NOPER; i++) begin
            chk($sformatf("fwd_data[%0d]", i), 64'(dut_data(i)), 64'(e.data[i]));
            chk($sformatf("fwd_src[%0d]", i), 64'(dut_src(i)), 64'(e.src[i]));
        end
        chk("stall_ex", 64'(bus.stall_ex), 64'(e.sex));
        chk("stall_id", 64'(bus.stall_id), 64'(e.sid));
        chk("stall_cnt", 64'(bus.stall_cnt), 64'(m_cnt));
    endtask

    task automatic sample();
        @(negedge CLK);
        check_all();
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < NOPER; i++) begin
            rs[i] = '0; rf[i] = $urandom(); id_rs[i] = '0;
        end
        for (int k = 0; k < NFWD; k++) begin
            dest[k] = '0; sdata[k] = $urandom();
        end
        regwr = '0; load = '0; dvalid = '1;
        memread = 1'b0; id_valid = 1'b0; pipe_en = 1'b1; wrdest = '0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        model_reset();
        sample();
        tick();
        RST = 1'b0;
    endtask

    task automatic set_pending(input logic [RADDR_W-1:0] r);
        regwr = 2'b11; load = 2'b01; dvalid = 2'b10;
        dest[0] = r; dest[1] = r;
        sdata[0] = 32'h1234_5678; sdata[1] = 32'h0000_0055;
        rs[0] = r; pipe_en = 1'b0;
    endtask

    initial begin
        clear_inputs();
        RST = 1'b1;
        model_reset();
        sample();
        chk("reset stall_cnt", 64'(bus.stall_cnt), 64'd0);
        chk("reset stall_id", 64'(bus.stall_id), 64'd0);
        chk("reset fwd_data[0]", 64'(dut_data(0)), 64'(rf[0]));
        tick();
        RST = 1'b0;

        // Youngest stage wins
        clear_inputs();
        regwr = 2'b11; dest[0] = 5; dest[1] = 5;
        sdata[0] = 32'hAAAA_0000; sdata[1] = 32'h0000_1111; rs[0] = 5;
        sample();
        chk("youngest data", 64'(dut_data(0)), 64'hAAAA_0000);
        chk("youngest src", 64'(dut_src(0)), 64'd1);
        tick();
        rs[0] = 0;
        sample();
        chk("r0 data", 64'(dut_data(0)), 64'(rf[0]));
        chk("r0 src", 64'(dut_src(0)), 64'd0);
        tick();

        // Pending load, no fall-through, MWAIT masks load-use
        do_reset();
        clear_inputs();
        set_pending(3);
        for (int c = 0; c < 3; c++) begin
            sample();
            chk("pend stall_ex", 64'(bus.stall_ex), 64'd1);
            chk("pend stall_id", 64'(bus.stall_id), 64'd1);
            chk("pend src", 64'(dut_src(0)), 64'd0);
            chk("pend data", 64'(dut_data(0)), 64'(rf[0]));
            tick();
        end
        dvalid = 2'b11;
        memread = 1'b1; wrdest = 3; id_valid = 1'b1; id_rs[0] = 3;
        sample();
        chk("dvalid stall_ex", 64'(bus.stall_ex), 64'd0);
        chk("dvalid data", 64'(dut_data(0)), 64'h1234_5678);
        chk("mwait stall_id", 64'(bus.stall_id), 64'd0);
        chk("pend stall_cnt", 64'(bus.stall_cnt), 64'd3);
        tick();
        sample();
        chk("post-mwait lu", 64'(bus.stall_id), 64'd1);
        chk("post-mwait src", 64'(dut_src(0)), 64'(NFWD + 1));
        tick();

        // Load-use: exactly one bubble
        do_reset();
        clear_inputs();
        memread = 1'b1; wrdest = 7; id_rs[1] = 7; id_valid = 1'b1;
        sample();
        chk("lu stall_id", 64'(bus.stall_id), 64'd1);
        chk("lu stall_ex", 64'(bus.stall_ex), 64'd0);
        tick();
        sample();
        chk("lu bubble stall_id", 64'(bus.stall_id), 64'd0);
        chk("lu stall_cnt", 64'(bus.stall_cnt), 64'd1);
        tick();
        sample();
        chk("lu rerun stall_id", 64'(bus.stall_id), 64'd1);
        tick();

        // Hold buffer across a freeze
        do_reset();
        clear_inputs();
        regwr[1] = 1'b1; dest[1] = 9; sdata[1] = 32'hDEAD_BEEF; rs[0] = 9; pipe_en = 1'b0;
        sample();
        chk("wb data", 64'(dut_data(0)), 64'hDEAD_BEEF);
        chk("wb src", 64'(dut_src(0)), 64'd2);
        tick();
        sdata[1] = 32'h0;
        sample();
        chk("hold data", 64'(dut_data(0)), 64'hDEAD_BEEF);
        chk("hold src", 64'(dut_src(0)), 64'(NFWD + 1));
        tick();
        pipe_en = 1'b1;
        sample();
        chk("hold last data", 64'(dut_data(0)), 64'hDEAD_BEEF);
        tick();
        sample();
        chk("released data", 64'(dut_data(0)), 64'd0);
        chk("released src", 64'(dut_src(0)), 64'd2);
        tick();

        // Counter saturation
        do_reset();
        clear_inputs();
        regwr[0] = 1'b1; load[0] = 1'b1; dvalid[0] = 1'b0; dest[0] = 4; rs[1] = 4;
        pipe_en = 1'b0;
        for (int c = 0; c < 20; c++) begin
            sample();
            tick();
        end
        dvalid[0] = 1'b1;
        sample();
        chk("sat stall_cnt", 64'(bus.stall_cnt), 64'(CNT_MAX));
        chk("sat stall_ex", 64'(bus.stall_ex), 64'd0);
        tick();

        // Asynchronous reset in the middle of MWAIT
        do_reset();
        clear_inputs();
        set_pending(6);
        sample(); tick();
        sample(); tick();
        #2;
        RST = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("async stall_ex", 64'(bus.stall_ex), 64'd0);
        chk("async stall_id", 64'(bus.stall_id), 64'd0);
        chk("async stall_cnt", 64'(bus.stall_cnt), 64'd0);
        chk("async src", 64'(dut_src(0)), 64'd0);
        tick();
        RST = 1'b0;
        clear_inputs();
        memread = 1'b1; wrdest = 7; id_rs[0] = 7; id_valid = 1'b1;
        sample();
        chk("after reset run", 64'(bus.stall_id), 64'd1);
        tick();

        // Randomized run
        clear_inputs();
        for (int n = 0; n < 2000; n++) begin
            RST = ($urandom_range(0, 99) == 0);
            if (RST) model_reset();
            if ($urandom_range(0, 1) == 1) begin
                for (int k = 0; k < NFWD; k++) begin
                    dest[k]  = RADDR_W'($urandom_range(0, 7));
                    sdata[k] = $urandom();
                end
                regwr  = NFWD'($urandom());
                load   = NFWD'($urandom());
                dvalid = NFWD'($urandom()) | NFWD'($urandom());
            end
            for (int i = 0; i < NOPER; i++) begin
                if ($urandom_range(0, 3) == 0) rs[i] = RADDR_W'($urandom_range(0, 7));
                if ($urandom_range(0, 3) == 0) id_rs[i] = RADDR_W'($urandom_range(0, 7));
                rf[i] = $urandom();
            end
            memread  = 1'($urandom());
            id_valid = 1'($urandom());
            wrdest   = RADDR_W'($urandom_range(0, 7));
            pipe_en  = 1'($urandom());
            sample();
            tick();
        end
        RST = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
Parametrised forwarding and hazard unit for the pipelined datapath. It resolves each EX-stage source operand against NFWD downstream pipeline stages, youngest first, and returns the forwarded operand data directly. It holds forwarded values across EX freezes and detects load-use hazards, including stalling on loads whose data is still pending. It also keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
NOPER, 2, number of EX source operands resolved per cycle
NFWD, 2, number of forwarding stages; index 0 is youngest (MEM), NFWD-1 is oldest (WB)
RADDR_W, 5, register address width
DATA_W, 32, data width
CNT_W, 16, stall counter width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-high
ex_rs  in  NOPER*RADDR_W  EX operand register numbers; operand i occupies [i*RADDR_W +: RADDR_W]
ex_rf_data  in  NOPER*DATA_W  register-file values latched for EX operands
st_regwr  in  NFWD  stage k writes a register
st_dest  in  NFWD*RADDR_W  destination register of stage k
st_data  in  NFWD*DATA_W  result of stage k
st_load  in  NFWD  stage k holds a load
st_dvalid  in  NFWD  load data in st_data is valid (dhit for MEM, 1 for WB)
ex_memread  in  1  instruction in EX is a load
ex_wrdest  in  RADDR_W  destination register of the EX instruction
id_rs  in  NOPER*RADDR_W  ID operand register numbers
id_valid  in  1  ID holds a real instruction
pipe_en  in  1  EX/MEM latch advances this cycle
fwd_data  out  NOPER*DATA_W  resolved operand values
fwd_src  out  NOPER*$clog2(NFWD+2)  operand source: 0 = regfile, k+1 = stage k, NFWD+1 = hold buffer
stall_id  out  1  freeze PC and IF/ID; insert a bubble into EX
stall_ex  out  1  freeze ID/EX and earlier; insert a bubble into MEM
stall_cnt  out  CNT_W  saturating count of cycles with stall_id or stall_ex high

Behaviour:
- Match condition, operand i vs stage k: st_regwr[k] && st_dest[k]!=0 && st_dest[k]==ex_rs[i]. The lowest k that matches wins. Register 0 never matches.
- Winner is a load with !st_dvalid[k]: operand i is pending.
  - Do not fall through to older stages.
  - fwd_data[i] = ex_rf_data[i], fwd_src[i] = 0.
- No match: fwd_data[i] = ex_rf_data[i], fwd_src[i] = 0.
- Hold buffer, per operand (hold[i], hold_v[i]):
  - While hold_v[i]=1, fwd_data[i]=hold[i] and fwd_src[i]=NFWD+1. This overrides all matching.
  - Capture at the clock edge when pipe_en=0, !hold_v[i], and operand i resolved from a stage without pending. Then hold[i] <= that stage data and hold_v[i] <= 1.
  - Clear: hold_v[i] <= 0 on any edge with pipe_en=1. Clear has priority over capture.
- stall_ex = OR over operands of pending (combinational).
- Load-use hazard lu = id_valid && ex_memread && ex_wrdest!=0 && ex_wrdest equals any id_rs[i].
- stall_id = stall_ex | (lu && state==RUN).
- FSM states: RUN, LU, MWAIT.
  - RUN: stall_ex goes to MWAIT. Else lu && pipe_en goes to LU. Else stay in RUN.
  - LU: one bubble cycle, then goes to RUN unconditionally. lu is ignored in LU.
  - MWAIT: stay while stall_ex; otherwise go to RUN.
  - stall_ex has priority over lu.
- stall_cnt increments by 1 each edge with stall_id|stall_ex and saturates at 2^CNT_W-1. It does not wrap.
- Reset (RST high, asynchronous):
  - state=RUN, hold_v=0, hold=0, stall_cnt=0.
  - stall_id and stall_ex are forced 0 while RST is high.
  - fwd_src=0 and fwd_data=ex_rf_data while RST is high.
  - Reset mid-stall discards the hold buffer and FSM state immediately.
- Latency: forwarding and stall outputs are combinational, same cycle. The hold buffer, FSM and counter are registered.

Test Plan:
- Youngest-wins priority: NFWD=2; stage0 and stage1 both write r5; ex_rs[0]=5, st_data0=0xAAAA0000, st_data1=0x1111 -> fwd_data[0]=0xAAAA0000, fwd_src[0]=1. Repeat with ex_rs=0 -> rf data, src 0.
- Pending load: stage0 load to r3 with st_dvalid0=0 for 3 cycles, stage1 also writes r3:
  - During those cycles: stall_ex=1, stall_id=1, no fall-through to stage1, FSM in MWAIT.
  - When dvalid rises: stall_ex=0, fwd_data=st_data0.
  - stall_cnt=3.
- Load-use: ex_memread=1, ex_wrdest=7, id_rs[1]=7, pipe_en=1 -> stall_id=1 for exactly one cycle. FSM goes RUN->LU->RUN. stall_cnt increments by 1.
- Hold buffer: WB forwards 0xDEADBEEF on r9 while pipe_en=0, then WB changes to 0x0. fwd_data stays 0xDEADBEEF with src=NFWD+1 until the edge with pipe_en=1; after that edge hold_v=0.
- Saturation: CNT_W=4; hold stall_ex for 20 cycles -> stall_cnt=15, no wrap.
- Reset mid-MWAIT: assert RST asynchronously while pending -> stall outputs go 0 immediately, hold_v=0, stall_cnt=0; after release, FSM is in RUN.
